// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and encodings for the buffered 1:2 demux.
// Holds FIFO depth, counter width, select and occupancy encodings.
package demux_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 8;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo2.sv
// fifo2: two-entry register FIFO, head data straight from storage.
// Ports: clk, rst (sync, active-high), push/wdata, pop, full, empty, rdata.
module fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             rptr;
    logic             wptr;
    occ_e             occ;
    occ_e             occ_nxt;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == OCC_2);
    assign empty   = (occ == OCC_0);
    assign rdata   = mem[rptr];

    // Guard locally so a misbehaving caller cannot corrupt occupancy.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        occ_nxt = occ;
        case (occ)
            OCC_0: begin
                if (do_push) occ_nxt = OCC_1;
            end
            OCC_1: begin
                if (do_push && !do_pop)      occ_nxt = OCC_2;
                else if (do_pop && !do_push) occ_nxt = OCC_0;
            end
            OCC_2: begin
                if (do_pop) occ_nxt = OCC_1;
            end
            default: occ_nxt = OCC_0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= OCC_0;
            rptr   <= 1'b0;
            wptr   <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            occ <= occ_nxt;
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
        end
    end

endmodule

// File: rtl/demux1_2_buf.sv
// demux1_2_buf: steers each input byte by sel into FIFO A or B.
// Ports: clk, rst, in_valid/in_data/sel/in_ready, a_* and b_* outputs,
// a_count/b_count (delivered bytes, mod 256).
module demux1_2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel,
    output logic             in_ready,
    output logic             a_valid,
    output logic [WIDTH-1:0] a_data,
    input  logic             a_ready,
    output logic             b_valid,
    output logic [WIDTH-1:0] b_data,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic a_full;
    logic a_empty;
    logic b_full;
    logic b_empty;
    logic push_a;
    logic push_b;
    logic pop_a;
    logic pop_b;
    logic to_b;

    assign to_b = (sel_e'(sel) == SEL_B);

    // Depends only on sel and registered occupancy: no ready-to-ready path.
    assign in_ready = to_b ? ~b_full : ~a_full;

    assign push_a = in_valid & in_ready & ~to_b;
    assign push_b = in_valid & in_ready & to_b;

    assign a_valid = ~a_empty;
    assign b_valid = ~b_empty;
    assign pop_a   = a_valid & a_ready;
    assign pop_b   = b_valid & b_ready;

    fifo2 #(.WIDTH(WIDTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (push_a),
        .wdata (in_data),
        .pop   (pop_a),
        .full  (a_full),
        .empty (a_empty),
        .rdata (a_data)
    );

    fifo2 #(.WIDTH(WIDTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b),
        .wdata (in_data),
        .pop   (pop_b),
        .full  (b_full),
        .empty (b_empty),
        .rdata (b_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (pop_a) a_count <= a_count + CNT_W'(1);
            if (pop_b) b_count <= b_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux1_2_buf.sv
// tb_demux1_2_buf: directed vector table, wrap/reset sequences and
// randomized traffic against a queue-based reference model.
module tb_demux1_2_buf;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       sel;
    logic       in_ready;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic [7:0] a_count;
    logic [7:0] b_count;

    int checks;
    int failures;

    demux1_2_buf #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .sel      (sel),
        .in_ready (in_ready),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       s;
        logic       ar;
        logic       br;
        logic       ck_rdy;
        logic       rdy;
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic [7:0] ac;
        logic [7:0] bc;
    } vec_t;

    vec_t tbl[$];

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         ca;
    int         cb;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [7:0] d,
                       input logic s, input logic ar, input logic br,
                       input logic ck_rdy, input logic rdy,
                       input logic av, input logic [7:0] ad,
                       input logic bv, input logic [7:0] bd,
                       input logic [7:0] ac, input logic [7:0] bc);
        vec_t e;
        e.r = r; e.v = v; e.d = d; e.s = s; e.ar = ar; e.br = br;
        e.ck_rdy = ck_rdy; e.rdy = rdy;
        e.av = av; e.ad = ad; e.bv = bv; e.bd = bd;
        e.ac = ac; e.bc = bc;
        tbl.push_back(e);
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] d,
                         input logic s, input logic ar, input logic br);
        rst      = r;
        in_valid = v;
        in_data  = d;
        sel      = s;
        a_ready  = ar;
        b_ready  = br;
        #1;
    endtask

    // Reference: a byte is taken when its destination holds fewer than
    // two; a head leaves when present and its consumer is ready.
    task automatic tick();
        bit take;
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
            ca = 0;
            cb = 0;
        end else begin
            take = in_valid && (sel ? qb.size() < 2 : qa.size() < 2);
            if (qa.size() != 0 && a_ready) begin
                void'(qa.pop_front());
                ca = (ca + 1) % 256;
            end
            if (qb.size() != 0 && b_ready) begin
                void'(qb.pop_front());
                cb = (cb + 1) % 256;
            end
            if (take) begin
                if (sel) qb.push_back(in_data);
                else     qa.push_back(in_data);
            end
        end
        @(negedge clk);
    endtask

    function automatic logic model_ready(input logic s);
        return s ? (qb.size() < 2) : (qa.size() < 2);
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, "_av"}, a_valid, qa.size() != 0);
        chk({tag, "_bv"}, b_valid, qb.size() != 0);
        if (qa.size() != 0) chk({tag, "_ad"}, a_data, qa[0]);
        if (qb.size() != 0) chk({tag, "_bd"}, b_data, qb[0]);
        chk({tag, "_ac"}, a_count, ca[7:0]);
        chk({tag, "_bc"}, b_count, cb[7:0]);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ca = 0;
        cb = 0;

        //  r v d     s ar br ckr rdy av ad    bv bd    ac bc
        add(1,0,8'h00,0,0,0, 0, 1, 0,8'h00, 0,8'h00, 0, 0);
        add(1,0,8'h00,0,0,0, 1, 1, 0,8'h00, 0,8'h00, 0, 0);
        add(0,0,8'h00,0,0,0, 1, 1, 0,8'h00, 0,8'h00, 0, 0);
        add(0,1,8'h3C,0,1,0, 1, 1, 1,8'h3C, 0,8'h00, 0, 0);
        add(0,0,8'h00,0,1,0, 1, 1, 0,8'h00, 0,8'h00, 1, 0);
        add(0,1,8'h11,1,0,0, 1, 1, 0,8'h00, 1,8'h11, 1, 0);
        add(0,1,8'h22,1,0,0, 1, 1, 0,8'h00, 1,8'h11, 1, 0);
        add(0,1,8'h33,1,0,0, 1, 0, 0,8'h00, 1,8'h11, 1, 0);
        add(0,1,8'h33,1,0,1, 1, 0, 0,8'h00, 1,8'h22, 1, 1);
        add(0,0,8'h00,1,0,1, 1, 1, 0,8'h00, 0,8'h00, 1, 2);
        add(0,1,8'h44,1,0,0, 1, 1, 0,8'h00, 1,8'h44, 1, 2);
        add(0,1,8'h55,1,0,0, 1, 1, 0,8'h00, 1,8'h44, 1, 2);
        add(0,1,8'h66,1,0,0, 1, 0, 0,8'h00, 1,8'h44, 1, 2);
        add(0,1,8'hA5,0,0,0, 1, 1, 1,8'hA5, 1,8'h44, 1, 2);
        add(0,0,8'h00,0,1,0, 1, 1, 0,8'h00, 1,8'h44, 2, 2);
        add(0,1,8'h01,0,0,0, 1, 1, 1,8'h01, 1,8'h44, 2, 2);
        add(0,1,8'h02,0,1,0, 1, 1, 1,8'h02, 1,8'h44, 3, 2);
        add(0,0,8'h00,1,1,0, 1, 0, 0,8'h00, 1,8'h44, 4, 2);
        add(0,0,8'h00,1,0,1, 1, 0, 0,8'h00, 1,8'h55, 4, 3);
        add(0,0,8'h00,1,0,1, 1, 1, 0,8'h00, 0,8'h00, 4, 4);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].s,
                  tbl[i].ar, tbl[i].br);
            if (tbl[i].ck_rdy)
                chk($sformatf("v%0d_rdy", i), in_ready, tbl[i].rdy);
            tick();
            chk($sformatf("v%0d_av", i), a_valid, tbl[i].av);
            chk($sformatf("v%0d_bv", i), b_valid, tbl[i].bv);
            if (tbl[i].av || tbl[i].r)
                chk($sformatf("v%0d_ad", i), a_data, tbl[i].ad);
            if (tbl[i].bv || tbl[i].r)
                chk($sformatf("v%0d_bd", i), b_data, tbl[i].bd);
            chk($sformatf("v%0d_ac", i), a_count, tbl[i].ac);
            chk($sformatf("v%0d_bc", i), b_count, tbl[i].bc);
        end

        // Counter wrap: 256 bytes through A with the consumer always ready.
        drive(1, 0, 8'h00, 0, 0, 0);
        tick();
        for (int i = 0; i < 256; i++) begin
            drive(0, 1, 8'(i), 0, 1, 0);
            if (i % 64 == 0) chk("wrap_rdy", in_ready, 1'b1);
            tick();
            if (i % 16 == 0 || i > 250) begin
                chk("wrap_ad", a_data, 32'(i));
                chk("wrap_ac", a_count, 32'(i));
            end
        end
        drive(0, 0, 8'h00, 0, 1, 0);
        tick();
        chk("wrap_ac0", a_count, 32'h0);
        chk("wrap_av0", a_valid, 1'b0);
        chk_model("wrap");

        // Mid-operation reset with a live input handshake presented.
        drive(0, 1, 8'h81, 1, 0, 0);
        tick();
        drive(0, 1, 8'h82, 1, 0, 0);
        tick();
        chk("mr_bfull", in_ready, 1'b0);
        chk_model("mr_fill");
        drive(1, 1, 8'h99, 0, 1, 0);
        tick();
        chk("mr_av", a_valid, 1'b0);
        chk("mr_bv", b_valid, 1'b0);
        chk("mr_ad", a_data, 32'h0);
        chk("mr_bd", b_data, 32'h0);
        chk("mr_ac", a_count, 32'h0);
        chk("mr_bc", b_count, 32'h0);
        drive(0, 0, 8'h00, 1, 1, 1);
        chk("mr_rdy", in_ready, 1'b1);
        tick();
        chk("mr_bv2", b_valid, 1'b0);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 7),
                  8'($urandom),
                  1'($urandom),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0));
            if (!rst) chk("rnd_rdy", in_ready, model_ready(sel));
            tick();
            chk_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
